mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: i_clk input 1 (rising-edge clock); i_rst_n input 1 (asynchronous reset, active-low).
REQ-002 SHALL have port i_mdu_type, input, `ARGS_WIDTH bits: operation. Only bits [2:0] are decoded: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-003 SHALL have port i_mdu_rs1_data, input, `DATA_WIDTH bits: multiplicand or dividend.
REQ-004 SHALL have port i_mdu_rs2_data, input, `DATA_WIDTH bits: multiplier or divisor.
REQ-005 SHALL have port i_mdu_valid, input, 1 bit: request valid.
REQ-006 SHALL have port o_mdu_ready, output, 1 bit: the unit can accept a request.
REQ-007 SHALL have port i_mdu_flush, input, 1 bit: synchronous abort.
REQ-008 SHALL have port o_mdu_res_valid, output, 1 bit: result valid.
REQ-009 SHALL have port i_mdu_res_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port o_mdu_res, output, `DATA_WIDTH bits: result.
REQ-011 SHALL have port o_mdu_div_zero, output, 1 bit: the current result came from a divisor of zero.

Function
REQ-012 SHALL use a three-state FSM: IDLE, CALC, DONE.
REQ-013 SHALL drive o_mdu_ready high only in IDLE.
REQ-014 SHALL accept a request on the rising edge where i_mdu_valid && o_mdu_ready, latching the operation and both operands; operand changes after that edge SHALL have no effect.
REQ-015 SHALL, on accept, move IDLE->CALC, except in special cases, which move IDLE->DONE.
REQ-016 SHALL, in CALC, run one radix-2 iteration per cycle with a counter that counts DATA_WIDTH iterations, then move CALC->DONE.
REQ-017 SHALL drive o_mdu_res_valid high only in DONE; iterative results SHALL be valid exactly DATA_WIDTH+1 cycles after the accept edge.
REQ-018 SHALL hold o_mdu_res and o_mdu_res_valid stable in DONE until i_mdu_res_ready; handshake edge moves DONE->IDLE.
REQ-019 SHALL make no combinational path from i_mdu_valid to o_mdu_ready: a new request is accepted no earlier than the cycle after the result handshake.
REQ-020 SHALL return MUL as the low DATA_WIDTH bits of the product.
REQ-021 SHALL return MULH, MULHSU and MULHU as the high DATA_WIDTH bits of the 2*DATA_WIDTH product, with operands signed×signed, signed×unsigned and unsigned×unsigned respectively.
REQ-022 SHALL run DIV and REM on magnitudes, then correct signs: quotient negative iff the operand signs differ; remainder takes the sign of the dividend.
REQ-023 SHALL treat divisor zero as a special case with 1-cycle latency: quotient all ones, remainder equal to the dividend, o_mdu_div_zero=1.
REQ-024 SHALL treat signed overflow (dividend = most-negative, divisor = -1, DIV/REM only) as a special case with 1-cycle latency: quotient = dividend, remainder = 0.
REQ-025 SHALL, on i_mdu_flush high at a rising edge in any state, go to IDLE and drop o_mdu_res_valid next cycle, with no result produced.
REQ-026 SHALL give flush priority over accept and over the result handshake in the same cycle.
REQ-027 SHALL clear o_mdu_div_zero whenever o_mdu_res_valid is low.

Reset
REQ-028 SHALL, while i_rst_n=0, immediately force state IDLE, counter 0, o_mdu_res=0, o_mdu_res_valid=0 and o_mdu_div_zero=0.
REQ-029 SHALL drive o_mdu_ready=1 on the first clock edge after reset release.
REQ-030 SHALL discard an in-flight operation when reset asserts mid-CALC; nothing SHALL be reported after reset release.

Configuration
REQ-031 SHALL use the macro MDU_FAST_MUL_EN; when it is defined, MUL/MULH/MULHSU/MULHU SHALL be computed by a single-cycle multiplier, going IDLE->DONE with the result valid 1 cycle after accept.
REQ-032 SHALL, when MDU_FAST_MUL_EN is undefined, compute multiplies by iterative shift-add in CALC, valid DATA_WIDTH+1 cycles after accept; result values SHALL be identical in both builds.
REQ-033 SHALL always perform division iteratively, independent of MDU_FAST_MUL_EN.

Verification (DATA_WIDTH=32)
REQ-034 SHALL cover MUL 7 × 0xFFFFFFFD -> o_mdu_res=0xFFFFFFEB, with o_mdu_res_valid at cycle 33 (cycle 1 with MDU_FAST_MUL_EN).
REQ-035 SHALL cover MULH 0x80000000 × 0x80000000 -> 0x40000000, and MULHU of the same operands -> 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-036 SHALL cover DIVU 100/7 -> 14; REMU -> 2; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF; DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
REQ-037 SHALL cover DIV 5/0 -> 0xFFFFFFFF with o_mdu_div_zero=1 at cycle 1; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-038 SHALL cover i_mdu_res_ready held low 10 cycles in DONE -> result stable, o_mdu_ready=0; then ready=1 -> IDLE next cycle.
REQ-039 SHALL cover i_mdu_flush at CALC iteration 10 -> no o_mdu_res_valid, o_mdu_ready=1 next cycle; reset asserted mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/mdu_if.sv
// Request/response bundle for the mdu multiply/divide unit.
// The testbench drives the flat mdu ports through an instance of this bundle.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 3
`endif

interface mdu_if;
    logic [`ARGS_WIDTH-1:0] mdu_type;
    logic [`DATA_WIDTH-1:0] rs1_data;
    logic [`DATA_WIDTH-1:0] rs2_data;
    logic                   valid;
    logic                   ready;
    logic                   flush;
    logic                   res_valid;
    logic                   res_ready;
    logic [`DATA_WIDTH-1:0] res;
    logic                   div_zero;

    modport master (
        output mdu_type, rs1_data, rs2_data, valid, flush, res_ready,
        input  ready, res_valid, res, div_zero
    );

    modport slave (
        input  mdu_type, rs1_data, rs2_data, valid, flush, res_ready,
        output ready, res_valid, res, div_zero
    );
endinterface

// File: rtl/mdu.sv
// Radix-2 iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Define MDU_FAST_MUL_EN to compute multiplies with a single-cycle multiplier instead.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 3
`endif

module mdu (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [`ARGS_WIDTH-1:0] i_mdu_type,
    input  logic [`DATA_WIDTH-1:0] i_mdu_rs1_data,
    input  logic [`DATA_WIDTH-1:0] i_mdu_rs2_data,
    input  logic                   i_mdu_valid,
    output logic                   o_mdu_ready,
    input  logic                   i_mdu_flush,
    output logic                   o_mdu_res_valid,
    input  logic                   i_mdu_res_ready,
    output logic [`DATA_WIDTH-1:0] o_mdu_res,
    output logic                   o_mdu_div_zero,
    output logic [1:0]             o_mdu_dbg_state
);
    localparam int W  = `DATA_WIDTH;
    localparam int PW = 2 * W;
    localparam int CW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    // Handshakes: a request transfers on a rising edge with i_mdu_valid && o_mdu_ready,
    // a result on a rising edge with o_mdu_res_valid && i_mdu_res_ready; i_mdu_flush
    // at an edge overrides both. Both ready and valid are registered outputs.

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic [PW-1:0] work_q, work_d;
    logic          neg_q, neg_d;
    logic          neg_rem_q, neg_rem_d;
    logic [W-1:0]  res_q, res_d;
    logic          res_valid_q, res_valid_d;
    logic          ready_q, ready_d;
    logic          div_zero_q, div_zero_d;

    if (`ARGS_WIDTH > 3) begin : g_type_hi
        logic unused_type_hi;
        assign unused_type_hi = |i_mdu_type[`ARGS_WIDTH-1:3];
    end

    logic [2:0]   op_in;
    logic         is_mul_in, a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;
    logic         div_by_zero, div_ovf;
    logic [W-1:0] special_res;

    assign op_in     = i_mdu_type[2:0];
    assign is_mul_in = ~op_in[2];
    assign a_signed  = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                       (op_in == OP_DIV)  || (op_in == OP_REM);
    assign b_signed  = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    assign a_neg     = a_signed & i_mdu_rs1_data[W-1];
    assign b_neg     = b_signed & i_mdu_rs2_data[W-1];
    assign a_mag     = a_neg ? -i_mdu_rs1_data : i_mdu_rs1_data;
    assign b_mag     = b_neg ? -i_mdu_rs2_data : i_mdu_rs2_data;

    assign div_by_zero = ~is_mul_in & (i_mdu_rs2_data == '0);
    assign div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                         (i_mdu_rs1_data == {1'b1, {(W-1){1'b0}}}) &&
                         (i_mdu_rs2_data == {W{1'b1}});

    // op bit 1 separates REM/REMU from DIV/DIVU within the divide group
    always_comb begin
        special_res = '0;
        if (div_by_zero) begin
            special_res = op_in[1] ? i_mdu_rs1_data : {W{1'b1}};
        end else if (div_ovf) begin
            special_res = op_in[1] ? '0 : i_mdu_rs1_data;
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic signed [W:0] fm_a, fm_b;
    logic [PW-1:0]     fm_prod;
    logic [W-1:0]      fast_res;

    assign fm_a     = {a_signed & i_mdu_rs1_data[W-1], i_mdu_rs1_data};
    assign fm_b     = {b_signed & i_mdu_rs2_data[W-1], i_mdu_rs2_data};
    assign fm_prod  = PW'(fm_a * fm_b);
    assign fast_res = (op_in == OP_MUL) ? fm_prod[W-1:0] : fm_prod[PW-1:W];
`endif

    // work_q holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
    logic [W:0]    mul_sum, div_shift, div_diff;
    logic [PW-1:0] mul_step, div_step, step_w;

    assign mul_sum   = {1'b0, work_q[PW-1:W]} + (work_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    assign mul_step  = {mul_sum, work_q[W-1:1]};
    assign div_shift = {work_q[PW-1:W], work_q[W-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_step  = div_diff[W] ? {div_shift[W-1:0], work_q[W-2:0], 1'b0}
                                   : {div_diff[W-1:0],  work_q[W-2:0], 1'b1};
    assign step_w    = op_q[2] ? div_step : mul_step;

    logic [PW-1:0] prod_fix;
    logic [W-1:0]  quo_fix, rem_fix, final_res;

    assign prod_fix = neg_q ? -step_w : step_w;
    assign quo_fix  = neg_q ? -step_w[W-1:0] : step_w[W-1:0];
    assign rem_fix  = neg_rem_q ? -step_w[PW-1:W] : step_w[PW-1:W];

    always_comb begin
        final_res = rem_fix;
        case (op_q)
            OP_MUL:                        final_res = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[PW-1:W];
            OP_DIV, OP_DIVU:               final_res = quo_fix;
            OP_REM, OP_REMU:               final_res = rem_fix;
            default:                       final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        opnd_d     = opnd_q;
        work_d     = work_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        res_d      = res_q;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (i_mdu_valid && ready_q) begin
                    op_d      = op_in;
                    cnt_d     = '0;
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (is_mul_in) begin
                        opnd_d = a_mag;
                        work_d = {{W{1'b0}}, b_mag};
                    end else begin
                        opnd_d = b_mag;
                        work_d = {{W{1'b0}}, a_mag};
                    end
                    if (div_by_zero || div_ovf) begin
                        state_d    = S_DONE;
                        res_d      = special_res;
                        div_zero_d = div_by_zero;
`ifdef MDU_FAST_MUL_EN
                    end else if (is_mul_in) begin
                        state_d    = S_DONE;
                        res_d      = fast_res;
                        div_zero_d = 1'b0;
`endif
                    end else begin
                        state_d    = S_CALC;
                        div_zero_d = 1'b0;
                    end
                end
            end
            S_CALC: begin
                work_d = step_w;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d    = S_DONE;
                    res_d      = final_res;
                    div_zero_d = 1'b0;
                end
            end
            S_DONE: begin
                if (i_mdu_res_ready) begin
                    state_d    = S_IDLE;
                    div_zero_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (i_mdu_flush) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            div_zero_d = 1'b0;
        end

        ready_d     = (state_d == S_IDLE);
        res_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_MUL;
            opnd_q      <= '0;
            work_q      <= '0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            opnd_q      <= opnd_d;
            work_q      <= work_d;
            neg_q       <= neg_d;
            neg_rem_q   <= neg_rem_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            ready_q     <= ready_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign o_mdu_ready     = ready_q;
    assign o_mdu_res_valid = res_valid_q;
    assign o_mdu_res       = res_q;
    assign o_mdu_div_zero  = div_zero_q & res_valid_q;
    assign o_mdu_dbg_state = state_q;

endmodule
